// File: rtl/bit_permuter_pkg.sv
// rtl/bit_permuter_pkg.sv - shared mode encodings for the bit permuter
package bit_permuter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_BITREV = 2'd1,
        MODE_GRPREV = 2'd2,
        MODE_ROTL   = 2'd3
    } perm_mode_e;

endpackage

// File: rtl/bit_permuter_perm_core.sv
// rtl/bit_permuter_perm_core.sv - combinational bit permutation network
module perm_core
    import bit_permuter_pkg::*;
#(
    parameter int N = 3,
    parameter int G = 2
) (
    input  logic [(1<<N)-1:0] a,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      rot,
    output logic [(1<<N)-1:0] y
);

    localparam int W  = 1 << N;
    localparam int GS = 1 << G;
    localparam int NG = W / GS;

    if (N < 1 || N > 6) begin : g_bad_n
        $error("perm_core: N=%0d outside 1..6", N);
    end
    if (G < 0 || G > N) begin : g_bad_g
        $error("perm_core: G=%0d outside 0..N", G);
    end

    logic [W-1:0]   bitrev;
    logic [W-1:0]   grprev;
    logic [2*W-1:0] dbl;

    // Mirror the word bit by bit.
    always_comb begin
        bitrev = '0;
        for (int i = 0; i < W; i++) begin
            bitrev[W-1-i] = a[i];
        end
    end

    // Reverse the order of whole groups while keeping each group intact.
    always_comb begin
        grprev = '0;
        for (int k = 0; k < NG; k++) begin
            grprev[k*GS +: GS] = a[(NG-1-k)*GS +: GS];
        end
    end

    // Rotation: shift a doubled word so the wrapped bits land in the top half.
    always_comb begin
        dbl = {a, a} << rot;
    end

    // Select the permutation requested for this word.
    always_comb begin
        y = a;
        case (perm_mode_e'(mode))
            MODE_PASS:   y = a;
            MODE_BITREV: y = bitrev;
            MODE_GRPREV: y = grprev;
            MODE_ROTL:   y = dbl[2*W-1:W];
            default:     y = a;
        endcase
    end

endmodule

// File: rtl/bit_permuter.sv
// rtl/bit_permuter.sv - flow-controlled bit permuter with 2-entry output buffer
module bit_permuter
    import bit_permuter_pkg::*;
#(
    parameter int N = 3,
    parameter int G = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [(1<<N)-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic [N-1:0]      in_rot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [(1<<N)-1:0] out_data
);

    localparam int W = 1 << N;

    logic [W-1:0] perm;
    logic [W-1:0] entry [2];
    logic [1:0]   count;
    logic         rd_ptr;
    logic         wr_ptr;
    logic         push;
    logic         pop;

    perm_core #(.N(N), .G(G)) u_core (
        .a    (in_data),
        .mode (in_mode),
        .rot  (in_rot),
        .y    (perm)
    );

    // Handshake flags come only from registered state, so no input reaches an output combinationally.
    always_comb begin
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);
        out_data  = entry[rd_ptr];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Two-entry FIFO: store the permuted word, advance pointers, track occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= perm;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_permuter.sv
// tb/tb_bit_permuter.sv - self-checking bench for bit_permuter
module tb_bit_permuter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_mode;
    logic [2:0] in_rot;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int cmp_count = 0;
    int err_count = 0;
    int sweep_done = 0;

    logic [7:0] q[$];

    always #5 clk = ~clk;

    bit_permuter #(.N(3), .G(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Reference: where does source bit i land, for a word of 2**n bits.
    function automatic logic [63:0] perm_ref(input int n, input int g, input logic [63:0] a,
                                             input int mode, input int rot);
        int w, gs, ng, j;
        logic [63:0] y;
        w  = 1 << n;
        gs = 1 << g;
        ng = w / gs;
        y  = '0;
        for (int i = 0; i < w; i++) begin
            case (mode)
                0:       j = i;
                1:       j = w - 1 - i;
                2:       j = (ng - 1 - i / gs) * gs + (i % gs);
                default: j = (i + rot) % w;
            endcase
            y[j] = a[i];
        end
        return y;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(q.size() != 2));
        if (q.size() != 0) chk({tag, "_out_data"}, 64'(out_data), 64'(q[0]));
    endtask

    // One clock: drive inputs, let the edge happen, advance the queue model, check.
    task automatic cycle(input string tag, input logic iv, input logic [7:0] d, input logic [1:0] m,
                         input logic [2:0] r, input logic ordy);
        logic push_m, pop_m;
        in_valid  = iv;
        in_data   = d;
        in_mode   = m;
        in_rot    = r;
        out_ready = ordy;
        push_m = iv && (q.size() != 2);
        pop_m  = ordy && (q.size() != 0);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
        end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back(8'(perm_ref(3, 2, 64'(d), int'(m), int'(r))));
        end
        check_state(tag);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic [2:0] rot;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    // Sweep of the permutation network over every legal N/G pair up to N=5.
    for (genvar n = 1; n <= 5; n++) begin : g_n
        for (genvar g = 0; g <= n; g++) begin : g_g
            localparam int W  = 1 << n;
            localparam int NN = n;
            logic [W-1:0]  a;
            logic [1:0]    mode;
            logic [NN-1:0] rot;
            logic [W-1:0]  y;

            perm_core #(.N(n), .G(g)) u_sw (.a(a), .mode(mode), .rot(rot), .y(y));

            initial begin
                for (int k = 0; k < 1000; k++) begin
                    a    = W'({$urandom, $urandom});
                    mode = 2'($urandom_range(0, 3));
                    rot  = NN'($urandom);
                    #1;
                    cmp_count++;
                    if (64'(y) !== perm_ref(n, g, 64'(a), int'(mode), int'(rot))) begin
                        err_count++;
                        $display("FAIL sweep_N%0d_G%0d a=%h mode=%0d rot=%0d actual=%h required=%h",
                                 n, g, a, mode, rot, y, perm_ref(n, g, 64'(a), int'(mode), int'(rot)));
                    end
                end
                sweep_done++;
            end
        end
    end

    initial begin
        vecs[0] = '{8'h86, 2'd0, 3'd0, 8'h86};
        vecs[1] = '{8'h86, 2'd1, 3'd0, 8'h61};
        vecs[2] = '{8'h86, 2'd2, 3'd0, 8'h68};
        vecs[3] = '{8'h86, 2'd3, 3'd3, 8'h34};
        vecs[4] = '{8'h86, 2'd3, 3'd0, 8'h86};

        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mode = '0; in_rot = '0; out_ready = 1'b0;

        // Reset held with in_valid high: nothing is stored.
        for (int i = 0; i < 2; i++) begin
            cycle("reset", 1'b1, 8'hFF, 2'd0, 3'd0, 1'b1);
            chk("reset_out_data", 64'(out_data), 64'h0);
            chk("reset_out_valid", 64'(out_valid), 64'h0);
        end
        reset = 1'b0;
        cycle("idle", 1'b0, 8'h00, 2'd0, 3'd0, 1'b1);
        chk("idle_out_valid", 64'(out_valid), 64'h0);

        // Mode table with the consumer always ready.
        for (int i = 0; i < 5; i++) begin
            cycle("mode", 1'b1, vecs[i].data, vecs[i].mode, vecs[i].rot, 1'b1);
            chk($sformatf("mode_vec%0d", i), 64'(out_data), 64'(vecs[i].exp));
        end
        cycle("drain", 1'b0, 8'h00, 2'd0, 3'd0, 1'b1);

        // Back-pressure: only two words fit.
        cycle("bp", 1'b1, 8'h01, 2'd0, 3'd0, 1'b0);
        cycle("bp", 1'b1, 8'h02, 2'd0, 3'd0, 1'b0);
        chk("bp_full_in_ready", 64'(in_ready), 64'h0);
        cycle("bp", 1'b1, 8'h03, 2'd0, 3'd0, 1'b0);
        chk("bp_hold_data", 64'(out_data), 64'h01);
        chk("bp_hold_ready", 64'(in_ready), 64'h0);
        cycle("bp", 1'b1, 8'h03, 2'd0, 3'd0, 1'b1);
        chk("bp_pop1_data", 64'(out_data), 64'h02);
        chk("bp_pop1_ready", 64'(in_ready), 64'h1);
        cycle("bp", 1'b1, 8'h03, 2'd0, 3'd0, 1'b1);
        chk("bp_pop2_data", 64'(out_data), 64'h03);
        cycle("bp", 1'b0, 8'h00, 2'd0, 3'd0, 1'b1);
        chk("bp_empty", 64'(out_valid), 64'h0);

        // Simultaneous push and pop at count 1.
        cycle("sim", 1'b1, 8'h10, 2'd0, 3'd0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cycle("sim", 1'b1, 8'(8'h10 + i), 2'd0, 3'd0, 1'b1);
            chk("sim_out_data", 64'(out_data), 64'(8'h10 + i));
            chk("sim_count1", 64'({out_valid, in_ready}), 64'h3);
        end
        cycle("sim", 1'b0, 8'h00, 2'd0, 3'd0, 1'b1);

        // Reset with two words buffered discards both.
        cycle("rst2", 1'b1, 8'hA1, 2'd0, 3'd0, 1'b0);
        cycle("rst2", 1'b1, 8'hA2, 2'd0, 3'd0, 1'b0);
        reset = 1'b1;
        cycle("rst2", 1'b1, 8'hA3, 2'd0, 3'd0, 1'b1);
        chk("rst2_out_valid", 64'(out_valid), 64'h0);
        reset = 1'b0;
        cycle("rst2", 1'b0, 8'h00, 2'd0, 3'd0, 1'b1);
        chk("rst2_still_empty", 64'(out_valid), 64'h0);
        cycle("rst2", 1'b1, 8'h5C, 2'd0, 3'd0, 1'b0);
        chk("rst2_new_word", 64'(out_data), 64'h5C);
        cycle("rst2", 1'b0, 8'h00, 2'd0, 3'd0, 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom), 8'($urandom), 2'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 2000 && sweep_done < 20; i++) @(posedge clk);
        chk("sweep_complete", 64'(sweep_done), 64'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/bit_permuter.md
# bit_permuter

Registered, flow-controlled bit-permutation unit and the parametrised successor of the combinational enable-gated word reverser. It accepts words of 2**N bits on a valid/ready input, applies one of four permutations chosen per word (pass, full bit reverse, group reverse, rotate-left), and returns the result through a 2-entry output buffer on a valid/ready output. It sits between any producer and consumer stage that needs back-pressure-safe bit reordering.

## Interface
- N, default 3: log2 of word width; W = 2**N bits. Legal range 1..6.
- G, default 2: log2 of group size for group-reverse mode. Legal range 0..N.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  W  word to permute.
- in_mode  input  2  permutation select, sampled with in_data.
- in_rot  input  N  rotate-left amount, used only in rotate mode.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  W  permuted word.

## Operation
- Transfer on the input side when in_valid && in_ready; on the output side when out_valid && out_ready.
- Mode encoding:
  - 0 PASS: y = a.
  - 1 BITREV: y[W-1-i] = a[i] for all i.
  - 2 GRPREV: the word is treated as W/2**G groups of 2**G bits; group order is reversed and bit order inside each group is kept. G=0 equals BITREV; G=N equals PASS.
  - 3 ROTL: y = a rotated left by in_rot; in_rot = 0 gives PASS. The amount is implicitly mod W, so there is no out-of-range case.
- The permutation is computed combinationally on the input side. The permuted word is what gets stored; mode and rot are not stored.
- Storage is a 2-entry FIFO with a count register (0..2), a read pointer and a write pointer (each 1 bit).
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - out_data = entry[read pointer].
- When a push and a pop happen together, count is unchanged and both pointers advance. A push and pop together with count==2 is impossible, because in_ready is low.
- Entries are never overwritten while occupied, and words leave in acceptance order.
- in_data, in_mode and in_rot are ignored whenever in_valid is low or in_ready is low.
- out_data is stable while out_valid && !out_ready.

## Timing
- Reset values: count=0, pointers=0, entries=0. So out_valid=0, in_ready=1, out_data=0 on the first cycle after reset.
- Reset mid-operation discards all buffered words. There is no output transfer in the reset cycle; out_ready is ignored during reset.
- Latency: a word accepted at edge k is visible on out_data with out_valid=1 after edge k. There is no combinational input-to-output path.
- Throughput: 1 word/cycle sustained when out_ready is held high (count stays at 1).
- in_ready depends only on registered state. It does not depend combinationally on out_ready, by decision.
- With out_ready low, exactly two words are accepted, then in_ready drops to 0 after the second acceptance edge. It returns to 1 on the cycle after the first pop.

## Structure
- Package bit_permuter_pkg holds:
  - typedef enum logic [1:0] perm_mode_e {MODE_PASS, MODE_BITREV, MODE_GRPREV, MODE_ROTL}.
  - Function-free constants only: the mode encodings.
- One sub-module, perm_core: purely combinational, parameters N and G, ports a, mode, rot, y. It holds all permutation logic; the top holds only the FIFO and handshake.
- Each illegal N/G combination stops elaboration with $error.

## Test plan
(N=3, G=2 unless stated)
- Reset: hold reset 2 cycles with in_valid=1 → out_valid=0, in_ready=1, out_data=0 throughout; no word is stored.
- Modes: send 8'h86 with out_ready=1 in each mode. Required outputs one cycle after acceptance, in order:
  - PASS → 8'h86.
  - BITREV → 8'h61.
  - GRPREV → 8'h68.
  - ROTL with rot=3 → 8'h34.
  - ROTL with rot=0 → 8'h86.
- Back-pressure: out_ready=0, offer 8'h01, 8'h02, 8'h03 in PASS on consecutive cycles.
  - Only 01 and 02 are accepted; in_ready=0 from the third cycle.
  - Then raise out_ready → 01, then 02, then 03 (accepted after space frees), with no loss or duplication.
- Simultaneous push/pop: with count=1, assert in_valid and out_ready together for 16 cycles on an incrementing stream → count stays 1 and outputs match the inputs in order, one per cycle.
- Reset mid-stream: with count=2, pulse reset for one cycle → out_valid=0 on the next cycle and the old words never appear.
- Parameter sweep: N=1..5, G=0..N, 1000 random words/modes/rots checked against a reference model. G=0 GRPREV must equal BITREV, and G=N GRPREV must equal PASS.
